csr_counter_bank: RTL and testbench

Parametrised machine-mode counter bank: cycle, instret and NUM_HPM programmable hardware performance counters (HPM counters), each CNT_W bits wide. Supports CSR read/write/set/clear, per-counter inhibit and per-HPM event selection. Sits beside the decode/execute stage and serves CSR instructions.

---
 rtl/csr_cnt_pkg.sv | 22 ++
 rtl/csr_counter.sv | 26 ++
 rtl/csr_counter_bank.sv | 105 ++++++++++
 tb/tb_csr_counter_bank.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/csr_cnt_pkg.sv
// csr_cnt_pkg: address map, CSR op encoding and read-modify-write helper
// shared by the counter bank.
package csr_cnt_pkg;
   localparam logic [11:0] ADDR_MCNT_LO = 12'hB00;
   localparam logic [11:0] ADDR_MCNT_HI = 12'hB80;
   localparam logic [11:0] ADDR_UCNT_LO = 12'hC00;
   localparam logic [11:0] ADDR_UCNT_HI = 12'hC80;
   localparam logic [11:0] ADDR_INHIBIT = 12'h320;
   localparam logic [11:0] ADDR_EVENT   = 12'h323;

   typedef enum logic [1:0] {
      CSR_READ  = 2'b00,
      CSR_WRITE = 2'b01,
      CSR_SET   = 2'b10,
      CSR_CLEAR = 2'b11
   } csr_op_e;

   function automatic logic [31:0] csr_wr_value(input csr_op_e op, input logic [31:0] old_v,
                                                input logic [31:0] wdata);
      return op == CSR_SET ? old_v | wdata : op == CSR_CLEAR ? old_v & ~wdata : wdata;
   endfunction
endpackage

// File: rtl/csr_counter.sv
// csr_counter: one CNT_W-bit counter; a half-word write replaces that half and
// suppresses the increment on the same edge.
module csr_counter #(
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             wr_lo_i,
   input  logic             wr_hi_i,
   input  logic [31:0]      wdata_i,
   output logic [CNT_W-1:0] cnt_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb
      cnt_d = wr_lo_i ? {cnt_q[CNT_W-1:32], wdata_i} :
              wr_hi_i ? {(CNT_W-32)'(wdata_i), cnt_q[31:0]} :
              cnt_q + CNT_W'(inc_i);

   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;

   assign cnt_o = cnt_q;
endmodule

// File: rtl/csr_counter_bank.sv
// csr_counter_bank: machine-mode cycle/instret/HPM counters with CSR access,
// per-counter inhibit and per-HPM event selection.
module csr_counter_bank import csr_cnt_pkg::*; #(
   parameter int NUM_HPM = 4,
   parameter int CNT_W   = 64,
   parameter int EVT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             instr_retire_i,
   input  logic [EVT_W-1:0] evt_in_i,
   input  logic             csr_en_i,
   input  logic [1:0]       csr_op_i,
   input  logic [11:0]      csr_addr_i,
   input  logic [31:0]      csr_wdata_i,
   output logic [31:0]      csr_rdata_o,
   output logic             csr_illegal_o
);
   localparam int NC = NUM_HPM + 2;
   localparam int NI = NUM_HPM + 3;
   localparam int NH = NUM_HPM > 0 ? NUM_HPM : 1;
   localparam int EW = $clog2(EVT_W + 1);
   localparam logic [NI-1:0] INH_MASK = ~NI'(2);

   logic [CNT_W-1:0] cnt [NC];
   logic [NC-1:0]    inc, wr_lo, wr_hi;
   logic [NI-1:0]    inh_q, inh_d;
   logic [EW-1:0]    evt_q [NH];
   logic [EW-1:0]    evt_d [NH];
   logic [4:0]       off, cidx;
   logic [11:0]      eoff;
   logic             is_cnt, is_hi, is_shadow, cnt_hit, inh_hit, evt_hit, illegal, wr;
   logic [CNT_W-1:0] cnt_sel;
   logic [EW-1:0]    evt_sel;
   logic [31:0]      rd_raw, wval;

   // Counter CSRs share one 32-entry window per base; offset 1 (time) is unmapped.
   assign off       = csr_addr_i[4:0];
   assign cidx      = off == 5'd0 ? 5'd0 : off - 5'd1;
   assign is_hi     = csr_addr_i[7];
   assign is_shadow = csr_addr_i[11:8] == ADDR_UCNT_LO[11:8];
   assign is_cnt    = csr_addr_i[6:5] == 2'b00 &&
                      ({csr_addr_i[11:7], 7'd0} inside {ADDR_MCNT_LO, ADDR_MCNT_HI, ADDR_UCNT_LO, ADDR_UCNT_HI});
   assign cnt_hit   = is_cnt && (off == 5'd0 || off == 5'd2 || (off >= 5'd3 && 32'(off) < 32'(NUM_HPM + 3)));
   assign inh_hit   = csr_addr_i == ADDR_INHIBIT;
   assign eoff      = csr_addr_i - ADDR_EVENT;
   assign evt_hit   = csr_addr_i >= ADDR_EVENT && 32'(eoff) < 32'(NUM_HPM);
   assign illegal   = csr_en_i && (!(cnt_hit || inh_hit || evt_hit) || (cnt_hit && is_shadow && csr_op_i != CSR_READ));
   assign wr        = csr_en_i && !illegal && csr_op_i != CSR_READ;

   always_comb begin
      cnt_sel = '0;
      evt_sel = '0;
      for (int i = 0; i < NC; i++) if (cidx == 5'(i)) cnt_sel = cnt[i];
      for (int i = 0; i < NUM_HPM; i++) if (eoff == 12'(i)) evt_sel = evt_q[i];
      rd_raw = cnt_hit ? (is_hi ? 32'(cnt_sel[CNT_W-1:32]) : cnt_sel[31:0]) :
               inh_hit ? 32'(inh_q) :
               evt_hit ? 32'(evt_sel) : '0;
   end

   assign wval          = csr_wr_value(csr_op_e'(csr_op_i), rd_raw, csr_wdata_i);
   assign csr_rdata_o   = csr_en_i && !illegal ? rd_raw : '0;
   assign csr_illegal_o = illegal;

   always_comb begin
      inc    = '0;
      wr_lo  = '0;
      wr_hi  = '0;
      inc[0] = !inh_q[0];
      inc[1] = instr_retire_i && !inh_q[2];
      for (int k = 0; k < NUM_HPM; k++)
         for (int j = 0; j < EVT_W; j++)
            if (evt_q[k] == EW'(j + 1) && evt_in_i[j] && !inh_q[3 + k]) inc[2 + k] = 1'b1;
      for (int i = 0; i < NC; i++) begin
         wr_lo[i] = wr && cnt_hit && !is_hi && cidx == 5'(i);
         wr_hi[i] = wr && cnt_hit && is_hi && cidx == 5'(i);
      end
   end

   always_comb begin
      inh_d = wr && inh_hit ? wval[NI-1:0] & INH_MASK : inh_q;
      for (int k = 0; k < NH; k++) evt_d[k] = wr && evt_hit && eoff == 12'(k) ? wval[EW-1:0] : evt_q[k];
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         inh_q <= '0;
         evt_q <= '{default: '0};
      end else begin
         inh_q <= inh_d;
         evt_q <= evt_d;
      end

   for (genvar i = 0; i < NC; i++) begin : g_cnt
      csr_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk     (clk),
         .rst     (rst),
         .inc_i   (inc[i]),
         .wr_lo_i (wr_lo[i]),
         .wr_hi_i (wr_hi[i]),
         .wdata_i (wval),
         .cnt_o   (cnt[i])
      );
   end
endmodule

// File: tb/tb_csr_counter_bank.sv
// tb_csr_counter_bank: directed and random CSR traffic against a behavioural
// model of the counter bank (NUM_HPM=4, CNT_W=40, EVT_W=8).
module tb_csr_counter_bank;
   localparam int NH = 4;
   localparam int CW = 40;
   localparam int EV = 8;
   localparam int EW = $clog2(EV + 1);
   localparam logic [63:0] MASK = (64'd1 << CW) - 64'd1;
   localparam logic [31:0] INHM = ((32'd1 << (NH + 3)) - 32'd1) & ~32'd2;

   logic          clk = 0, rst = 1, instr_retire = 0, csr_en = 0, csr_illegal;
   logic [EV-1:0] evt_in = '0;
   logic [1:0]    csr_op = 0;
   logic [11:0]   csr_addr = 0;
   logic [31:0]   csr_wdata = 0, csr_rdata;
   int            n_tests = 0, n_fail = 0;
   bit            lit_on = 0;
   string         lit_name = "";
   logic [31:0]   lit_rd = 0;
   bit            lit_ill = 0;

   logic [63:0] m_cnt [NH+2];
   logic [31:0] m_inh;
   logic [31:0] m_evt [NH];

   always #5 clk = ~clk;

   csr_counter_bank #(.NUM_HPM(NH), .CNT_W(CW), .EVT_W(EV)) dut (
      .clk            (clk),
      .rst            (rst),
      .instr_retire_i (instr_retire),
      .evt_in_i       (evt_in),
      .csr_en_i       (csr_en),
      .csr_op_i       (csr_op),
      .csr_addr_i     (csr_addr),
      .csr_wdata_i    (csr_wdata),
      .csr_rdata_o    (csr_rdata),
      .csr_illegal_o  (csr_illegal)
   );

   // Counter i lives at offset 0 (cycle), 2 (instret) or i+1 (hpm3..).
   function automatic int cnt_offset(input int i);
      return i == 0 ? 0 : i == 1 ? 2 : i + 1;
   endfunction

   // kind: 0 unmapped, 1 counter, 2 mcountinhibit, 3 mhpmevent
   function automatic void decode(input logic [11:0] a, output int kind, output int idx,
                                  output bit hi, output bit shadow);
      int ai = int'(a);
      kind = 0; idx = 0; hi = 0; shadow = 0;
      for (int i = 0; i < NH + 2; i++) begin
         int o = cnt_offset(i);
         if (ai == 'hB00 + o) begin kind = 1; idx = i; end
         if (ai == 'hB80 + o) begin kind = 1; idx = i; hi = 1; end
         if (ai == 'hC00 + o) begin kind = 1; idx = i; shadow = 1; end
         if (ai == 'hC80 + o) begin kind = 1; idx = i; hi = 1; shadow = 1; end
      end
      if (ai == 'h320) kind = 2;
      for (int k = 0; k < NH; k++) if (ai == 'h323 + k) begin kind = 3; idx = k; end
   endfunction

   function automatic void model_read(input logic [11:0] a, input logic [1:0] op, input bit en,
                                      output logic [31:0] rd, output bit ill);
      int kind, idx;
      bit hi, sh;
      decode(a, kind, idx, hi, sh);
      ill = en && (kind == 0 || (kind == 1 && sh && op != 2'b00));
      rd  = (!en || ill) ? 32'd0 :
            kind == 1 ? (hi ? m_cnt[idx][63:32] : m_cnt[idx][31:0]) :
            kind == 2 ? m_inh : m_evt[idx];
   endfunction

   task automatic model_step();
      int kind, idx;
      bit hi, sh, ill, wr;
      logic [31:0] rd, nv;
      bit [NH+1:0] inc;
      model_read(csr_addr, csr_op, csr_en, rd, ill);
      decode(csr_addr, kind, idx, hi, sh);
      wr = csr_en && !ill && csr_op != 2'b00;
      case (csr_op)
         2'b01:   nv = csr_wdata;
         2'b10:   nv = rd | csr_wdata;
         2'b11:   nv = rd & ~csr_wdata;
         default: nv = rd;
      endcase
      inc[0] = !m_inh[0];
      inc[1] = instr_retire && !m_inh[2];
      for (int k = 0; k < NH; k++)
         inc[2+k] = m_evt[k] >= 1 && m_evt[k] <= EV && evt_in[m_evt[k]-1] && !m_inh[3+k];
      for (int i = 0; i < NH + 2; i++)
         if (wr && kind == 1 && idx == i) m_cnt[i] = (hi ? {nv, m_cnt[i][31:0]} : {m_cnt[i][63:32], nv}) & MASK;
         else if (inc[i]) m_cnt[i] = (m_cnt[i] + 64'd1) & MASK;
      if (wr && kind == 2) m_inh = nv & INHM;
      if (wr && kind == 3) m_evt[idx] = nv & ((32'd1 << EW) - 32'd1);
   endtask

   always @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < NH + 2; i++) m_cnt[i] = 0;
         for (int k = 0; k < NH; k++) m_evt[k] = 0;
         m_inh = 0;
      end else model_step();

   always @(negedge clk) begin : cmp
      logic [31:0] erd;
      bit eill;
      model_read(csr_addr, csr_op, csr_en, erd, eill);
      n_tests++;
      if (csr_rdata !== erd || csr_illegal !== eill) begin
         n_fail++;
         $display("FAIL model addr=%h op=%0d en=%0b: rdata=%h illegal=%b, expected rdata=%h illegal=%b",
                  csr_addr, csr_op, csr_en, csr_rdata, csr_illegal, erd, eill);
      end
      if (lit_on) begin
         n_tests++;
         if (csr_rdata !== lit_rd || csr_illegal !== lit_ill) begin
            n_fail++;
            $display("FAIL %s: rdata=%h illegal=%b, expected rdata=%h illegal=%b",
                     lit_name, csr_rdata, csr_illegal, lit_rd, lit_ill);
         end
      end
   end

   task automatic drive(input bit en, input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                        input bit ret = 0, input logic [EV-1:0] ev = '0);
      @(posedge clk);
      #1;
      csr_en = en; csr_op = op; csr_addr = a; csr_wdata = wd; instr_retire = ret; evt_in = ev; lit_on = 0;
   endtask

   task automatic expect_rd(input string nm, input logic [31:0] rd, input bit ill = 0);
      lit_name = nm; lit_rd = rd; lit_ill = ill; lit_on = 1;
   endtask

   logic [11:0] addr_tbl [23] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB04, 12'hB86,
                                  12'hB07, 12'hC00, 12'hC80, 12'hC02, 12'hC05, 12'hC86, 12'h320, 12'h323,
                                  12'h326, 12'h327, 12'h321, 12'hB01, 12'hC01, 12'h000, 12'hB1F};

   initial begin
      drive(0, 0, 0, 0);               expect_rd("reset_idle", 0, 0);
      drive(1, 0, 12'hB00, 0);         expect_rd("reset_read_b00", 0, 0);
      rst = 0;
      for (int i = 0; i < 9; i++) drive(0, 0, 0, 0);
      drive(1, 0, 12'hC00, 0);         expect_rd("cycle_after_10", 10);
      drive(1, 0, 12'hC80, 0);         expect_rd("cycle_hi_zero", 0);
      drive(1, 0, 12'hB02, 0);         expect_rd("instret_zero", 0);

      drive(1, 1, 12'hB00, 32'hFFFF_FFFF);
      drive(1, 1, 12'hB80, 32'h1);
      drive(1, 0, 12'hC00, 0);         expect_rd("hi_write_no_inc", 32'hFFFF_FFFF);
      drive(1, 0, 12'hC80, 0);         expect_rd("carry_into_hi", 2);
      drive(1, 0, 12'hC00, 0);         expect_rd("lo_after_carry", 1);

      drive(1, 1, 12'h323, 3);
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 8'b0000_0100);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 8'b0000_0001);
      drive(1, 0, 12'hB03, 0);         expect_rd("hpm3_count", 5);
      drive(1, 2, 12'h320, 32'h8);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 8'b0000_0100);
      drive(1, 0, 12'hB03, 0);         expect_rd("hpm3_inhibited", 5);
      drive(1, 3, 12'h320, 32'h8, 0, 8'b0000_0100);
      drive(1, 0, 12'hB03, 0);         expect_rd("inhibit_clear_edge_old", 5);
      drive(1, 2, 12'h320, 32'h8, 0, 8'b0000_0100);
      drive(1, 0, 12'hB03, 0);         expect_rd("inhibit_set_edge_old", 6);
      drive(1, 1, 12'h320, 0);

      drive(1, 2, 12'h320, 32'h4);
      drive(1, 1, 12'hB82, 32'hFFFF_FFFF);
      drive(1, 1, 12'hB02, 32'hFFFF_FFFF);
      drive(1, 0, 12'hB82, 0);         expect_rd("hi_truncated", 32'h0000_00FF);
      drive(1, 3, 12'h320, 32'h4);
      drive(1, 0, 12'hB02, 0, 1);      expect_rd("instret_pre_wrap", 32'hFFFF_FFFF);
      drive(1, 0, 12'hB02, 0);         expect_rd("instret_wrap_lo", 0);
      drive(1, 0, 12'hB82, 0);         expect_rd("instret_wrap_hi", 0);

      drive(1, 1, 12'hC00, 32'h5);     expect_rd("shadow_write_illegal", 0, 1);
      drive(1, 0, 12'hB07, 0);         expect_rd("hpm_out_of_range", 0, 1);
      drive(1, 0, 12'h321, 0);         expect_rd("unmapped_321", 0, 1);
      drive(1, 1, 12'h320, 32'hFFFF_FFFF);
      drive(1, 0, 12'h320, 0);         expect_rd("inhibit_mask", 32'h7D);
      drive(1, 1, 12'h320, 0);
      drive(1, 1, 12'h324, 32'hFF);
      drive(1, 0, 12'h324, 0);         expect_rd("event_width", 32'hF);

      drive(1, 1, 12'hB00, 32'h1234);
      drive(1, 0, 12'hC00, 0);         expect_rd("pre_reset_value", 32'h1234);
      drive(1, 1, 12'hB00, 32'h55);
      rst = 1;                         expect_rd("reset_mid_write", 0);
      drive(1, 0, 12'hC00, 0);         expect_rd("reset_held", 0);
      rst = 0;
      drive(1, 0, 12'hC00, 0);         expect_rd("first_inc_after_reset", 1);

      for (int n = 0; n < 3000; n++) begin
         logic [11:0] a;
         logic [31:0] wd;
         int r = $urandom_range(0, 3);
         a  = $urandom_range(0, 7) == 0 ? 12'($urandom) : addr_tbl[$urandom_range(0, 22)];
         wd = r == 0 ? 32'h0 : r == 1 ? 32'hFFFF_FFFF : r == 2 ? $urandom : $urandom_range(0, 10);
         drive($urandom_range(0, 1) == 1, 2'($urandom), a, wd, $urandom_range(0, 1) == 1, EV'($urandom));
         rst = !rst && $urandom_range(0, 599) == 0;
      end
      rst = 0;
      drive(0, 0, 0, 0);
      @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
